imm_gen_stage: RTL and testbench

//  Registered, parametrised immediate generator for the decode stage. Extracts and

---
 rtl/imm_gen_stage.sv | 144 ++++++++++++++
 tb/tb_imm_gen_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RISC-V immediate generator with a 2-entry skid buffer
//   clk, rst_n (async, active low), flush (sync discard of all entries)
//   in_valid/in_ready, inst, in_pc          : upstream handshake and instruction
//   out_valid/out_ready, imm, imm_type,
//   out_inst, out_pc                        : downstream handshake and decoded entry
//   imm_type: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (zimm), 7 X (unknown/none)
module imm_gen_stage #(
  parameter int XLEN   = 32,
  parameter bit EN_FP  = 1'b1,
  parameter bit EN_CSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc
);
  logic               w_s;
  logic signed [31:0] w_imm32;
  logic [2:0]         w_type;
  logic [XLEN-1:0]    w_imm;
  logic               w_accept;
  logic               w_retire;
  logic               w_load_out;
  logic               r_out_valid;
  logic [XLEN-1:0]    r_imm;
  logic [2:0]         r_type;
  logic [31:0]        r_inst;
  logic [XLEN-1:0]    r_pc;
  logic               r_skid_valid;
  logic [XLEN-1:0]    r_s_imm;
  logic [2:0]         r_s_type;
  logic [31:0]        r_s_inst;
  logic [XLEN-1:0]    r_s_pc;

  assign w_s = inst[31];

  always_comb begin
    w_imm32 = '0;
    w_type  = 3'd7;
    if (inst[1:0] == 2'b11)
      case (inst[6:2])
        5'b01100: w_type = 3'd0;
        5'b00000, 5'b11001, 5'b00100: begin
          w_type  = 3'd1;
          w_imm32 = {{20{w_s}}, inst[31:20]};
        end
        5'b01000: begin
          w_type  = 3'd2;
          w_imm32 = {{20{w_s}}, inst[31:25], inst[11:7]};
        end
        5'b11000: begin
          w_type  = 3'd3;
          w_imm32 = {{20{w_s}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        5'b01101, 5'b00101: begin
          w_type  = 3'd4;
          w_imm32 = {inst[31:12], 12'b0};
        end
        5'b11011: begin
          w_type  = 3'd5;
          w_imm32 = {{12{w_s}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        end
        5'b00001: if (EN_FP) begin
          w_type  = 3'd1;
          w_imm32 = {{20{w_s}}, inst[31:20]};
        end
        5'b01001: if (EN_FP) begin
          w_type  = 3'd2;
          w_imm32 = {{20{w_s}}, inst[31:25], inst[11:7]};
        end
        5'b10100: if (EN_FP) w_type = 3'd0;
        5'b11100: if (EN_CSR) begin
          w_type  = 3'd6;
          w_imm32 = {27'b0, inst[19:15]};
        end
        default: ;
      endcase
  end

  // signed source operand makes the width cast sign-extend for XLEN=64
  assign w_imm = XLEN'(w_imm32);

  assign w_accept   = in_valid && !r_skid_valid;
  assign w_retire   = r_out_valid && out_ready;
  assign w_load_out = !r_out_valid || w_retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_imm        <= '0;
      r_type       <= 3'd7;
      r_inst       <= '0;
      r_pc         <= '0;
      r_skid_valid <= 1'b0;
      r_s_imm      <= '0;
      r_s_type     <= 3'd7;
      r_s_inst     <= '0;
      r_s_pc       <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      // entry 0 refills from the skid first so ordering stays FIFO
      if (w_load_out) begin
        r_out_valid <= r_skid_valid || w_accept;
        if (r_skid_valid) begin
          r_imm  <= r_s_imm;
          r_type <= r_s_type;
          r_inst <= r_s_inst;
          r_pc   <= r_s_pc;
        end else if (w_accept) begin
          r_imm  <= w_imm;
          r_type <= w_type;
          r_inst <= inst;
          r_pc   <= in_pc;
        end
      end
      if (w_retire) r_skid_valid <= 1'b0;
      else if (r_out_valid && w_accept) begin
        r_skid_valid <= 1'b1;
        r_s_imm      <= w_imm;
        r_s_type     <= w_type;
        r_s_inst     <= inst;
        r_s_pc       <= in_pc;
      end
    end
  end

  assign in_ready  = !r_skid_valid;
  assign out_valid = r_out_valid;
  assign imm       = r_imm;
  assign imm_type  = r_type;
  assign out_inst  = r_inst;
  assign out_pc    = r_pc;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: checks a 32-bit full-featured and a 64-bit no-FP/no-CSR instance
module tb_imm_gen_stage;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] inst;
  logic [63:0] in_pc64;
  logic        out_ready;
  logic        o1_ready, o1_valid, o2_ready, o2_valid;
  logic [31:0] o1_imm, o1_inst, o1_pc, o2_inst;
  logic [63:0] o2_imm, o2_pc;
  logic [2:0]  o1_type, o2_type;
  int tests = 0;
  int fails = 0;

  typedef struct {logic [31:0] inst; logic [63:0] pc;} ent_t;
  ent_t q[$];
  logic [31:0] obs[$];

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [2:0]  t32;
    logic [63:0] imm64;
    logic [2:0]  t64;
  } vec_t;
  vec_t vt[11];

  imm_gen_stage #(.XLEN(32), .EN_FP(1'b1), .EN_CSR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o1_ready),
    .inst(inst), .in_pc(in_pc64[31:0]), .out_valid(o1_valid), .out_ready(out_ready),
    .imm(o1_imm), .imm_type(o1_type), .out_inst(o1_inst), .out_pc(o1_pc));

  imm_gen_stage #(.XLEN(64), .EN_FP(1'b0), .EN_CSR(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o2_ready),
    .inst(inst), .in_pc(in_pc64), .out_valid(o2_valid), .out_ready(out_ready),
    .imm(o2_imm), .imm_type(o2_type), .out_inst(o2_inst), .out_pc(o2_pc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string n, input logic [63:0] g, input logic [63:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, g, e);
    end
  endtask

  // reference decoder built from the immediate bit-field rules using arithmetic shifts
  function automatic void ref_dec(input logic [31:0] i, input bit fp, input bit csr,
                                  output logic [63:0] v, output logic [2:0] t);
    logic signed [63:0] sx;
    logic [63:0] sg0, sg20, sg25, sg31;
    int op;
    sx   = 64'($signed(i));
    sg0  = sx;
    sg20 = sx >>> 20;
    sg25 = sx >>> 25;
    sg31 = sx >>> 31;
    op   = int'(i[6:2]);
    v = 64'd0;
    t = 3'd7;
    if (i[1:0] == 2'b11) begin
      if (op == 12 || (fp && op == 20)) t = 3'd0;
      else if (op == 0 || op == 25 || op == 4 || (fp && op == 1)) begin
        t = 3'd1; v = sg20;
      end else if (op == 8 || (fp && op == 9)) begin
        t = 3'd2; v = (sg25 << 5) | 64'(i[11:7]);
      end else if (op == 24) begin
        t = 3'd3;
        v = (sg31 << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
      end else if (op == 13 || op == 5) begin
        t = 3'd4; v = sg0 & ~64'hFFF;
      end else if (op == 27) begin
        t = 3'd5;
        v = (sg31 << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
      end else if (csr && op == 28) begin
        t = 3'd6; v = 64'(i[19:15]);
      end
    end
  endfunction

  task automatic check_model();
    logic [63:0] v;
    logic [2:0]  t;
    check("valid1", 64'(o1_valid), 64'(q.size() > 0));
    check("ready1", 64'(o1_ready), 64'(q.size() < 2));
    check("valid2", 64'(o2_valid), 64'(q.size() > 0));
    check("ready2", 64'(o2_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      ref_dec(q[0].inst, 1'b1, 1'b1, v, t);
      check("imm1", 64'(o1_imm), 64'(v[31:0]));
      check("type1", 64'(o1_type), 64'(t));
      check("inst1", 64'(o1_inst), 64'(q[0].inst));
      check("pc1", 64'(o1_pc), 64'(q[0].pc[31:0]));
      ref_dec(q[0].inst, 1'b0, 1'b0, v, t);
      check("imm2", o2_imm, v);
      check("type2", 64'(o2_type), 64'(t));
      check("inst2", 64'(o2_inst), 64'(q[0].inst));
      check("pc2", o2_pc, q[0].pc);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] ins, input logic [63:0] pc,
                      input logic ordy, input logic fl);
    bit acc, ret;
    in_valid  = iv;
    inst      = ins;
    in_pc64   = pc;
    out_ready = ordy;
    flush     = fl;
    acc = iv && q.size() < 2 && !fl;
    ret = q.size() > 0 && ordy && !fl;
    if (o1_valid && ordy && !fl) obs.push_back(o1_inst);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back('{ins, pc});
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic check_reset(input string n);
    check({n, "_valid"}, 64'({o1_valid, o2_valid}), 64'd0);
    check({n, "_ready"}, 64'({o1_ready, o2_ready}), 64'd3);
    check({n, "_imm1"}, 64'(o1_imm), 64'd0);
    check({n, "_imm2"}, o2_imm, 64'd0);
    check({n, "_type"}, 64'({o1_type, o2_type}), 64'o77);
    check({n, "_inst"}, 64'({o1_inst, o2_inst}), 64'd0);
    check({n, "_pc"}, 64'(o1_pc) | o2_pc, 64'd0);
  endtask

  initial begin
    logic        hold, iv, ordy, fl;
    logic [31:0] ins;
    logic [63:0] pc;
    vt[0]  = '{"addi",  32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1};
    vt[1]  = '{"beq",   32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3};
    vt[2]  = '{"lui",   32'h12345037, 32'h12345000, 3'd4, 64'h0000000012345000, 3'd4};
    vt[3]  = '{"luineg",32'h80000037, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4};
    vt[4]  = '{"flw",   32'h00452087, 32'h00000004, 3'd1, 64'h0, 3'd7};
    vt[5]  = '{"csrrwi",32'h3401D073, 32'h00000003, 3'd6, 64'h0, 3'd7};
    vt[6]  = '{"add",   32'h00B50533, 32'h00000000, 3'd0, 64'h0, 3'd0};
    vt[7]  = '{"sw",    32'hFE112E23, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2};
    vt[8]  = '{"jal",   32'h0080006F, 32'h00000008, 3'd5, 64'h8, 3'd5};
    vt[9]  = '{"lowbits",32'hFFF00090, 32'h0, 3'd7, 64'h0, 3'd7};
    vt[10] = '{"fadd",  32'h00000053, 32'h0, 3'd0, 64'h0, 3'd7};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; inst = '0; in_pc64 = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    foreach (vt[k]) begin
      step(1'b1, vt[k].inst, 64'h1000 + 64'(k * 4), 1'b1, 1'b0);
      check({vt[k].name, "_imm32"}, 64'(o1_imm), 64'(vt[k].imm32));
      check({vt[k].name, "_t32"}, 64'(o1_type), 64'(vt[k].t32));
      check({vt[k].name, "_imm64"}, o2_imm, vt[k].imm64);
      check({vt[k].name, "_t64"}, 64'(o2_type), 64'(vt[k].t64));
      step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    end
    obs.delete();
    step(1'b1, 32'hA0000013, 64'hA0, 1'b0, 1'b0);
    step(1'b1, 32'hB0000013, 64'hB0, 1'b0, 1'b0);
    check("abc_stall_ready", 64'(o1_ready), 64'd0);
    step(1'b1, 32'hC0000013, 64'hC0, 1'b0, 1'b0);
    step(1'b1, 32'hC0000013, 64'hC0, 1'b0, 1'b0);
    step(1'b1, 32'hC0000013, 64'hC0, 1'b1, 1'b0);
    step(1'b1, 32'hC0000013, 64'hC0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("abc_count", 64'(obs.size()), 64'd3);
    if (obs.size() == 3) begin
      check("abc_0", 64'(obs[0]), 64'hA0000013);
      check("abc_1", 64'(obs[1]), 64'hB0000013);
      check("abc_2", 64'(obs[2]), 64'hC0000013);
    end
    step(1'b1, 32'h00100093, 64'h10, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 64'h20, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 64'h30, 1'b1, 1'b1);
    check("flush_valid", 64'(o1_valid), 64'd0);
    check("flush_ready", 64'(o1_ready), 64'd1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    step(1'b1, 32'h00400093, 64'h40, 1'b0, 1'b0);
    step(1'b1, 32'h00500093, 64'h50, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("arst_valid", 64'({o1_valid, o2_valid}), 64'd0);
    check("arst_type", 64'({o1_type, o2_type}), 64'o77);
    check("arst_ready", 64'({o1_ready, o2_ready}), 64'd3);
    q.delete();
    @(negedge clk);
    check_reset("arst");
    rst_n = 1'b1;
    hold = 1'b0; iv = 1'b0; ins = '0; pc = '0;
    for (int n = 0; n < 500; n++) begin
      if (!hold) begin
        iv  = $urandom_range(0, 3) != 0;
        ins = $urandom;
        if ($urandom_range(0, 7) != 0) ins[1:0] = 2'b11;
        pc = {$urandom, $urandom};
      end
      ordy = $urandom_range(0, 2) != 0;
      fl   = $urandom_range(0, 29) == 0;
      hold = iv && q.size() >= 2 && !fl;
      step(iv, ins, pc, ordy, fl);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
